// File: rtl/pixel_coord_gen.sv
// Raster-scan coordinate generator: walks an H_PIXELS x V_PIXELS frame and emits
// the matching fixed-point complex-plane coordinate per pixel under valid/ready.
module pixel_coord_gen #(
  parameter int PIXEL_DATA_WIDTH   = 10,
  parameter int ENGINE_DATA_WIDTH  = 25,
  parameter int ENGINE_FRACT_WIDTH = 20,
  parameter int H_PIXELS           = 640,
  parameter int V_PIXELS           = 480
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                start,
  input  logic signed [ENGINE_DATA_WIDTH-1:0] x_min,
  input  logic signed [ENGINE_DATA_WIDTH-1:0] y_min,
  input  logic signed [ENGINE_DATA_WIDTH-1:0] step,
  input  logic                                out_ready,
  output logic                                out_valid,
  output logic signed [ENGINE_DATA_WIDTH-1:0] real_x,
  output logic signed [ENGINE_DATA_WIDTH-1:0] imag_y,
  output logic        [PIXEL_DATA_WIDTH-1:0]  pixel_x,
  output logic        [PIXEL_DATA_WIDTH-1:0]  pixel_y,
  output logic                                sof,
  output logic                                eol,
  output logic                                busy,
  output logic                                frame_done
);

  localparam logic [PIXEL_DATA_WIDTH-1:0] LAST_COL = PIXEL_DATA_WIDTH'(H_PIXELS - 1);
  localparam logic [PIXEL_DATA_WIDTH-1:0] LAST_ROW = PIXEL_DATA_WIDTH'(V_PIXELS - 1);

  // Elaboration-time guards on the parameter set.
  if (ENGINE_FRACT_WIDTH >= ENGINE_DATA_WIDTH) begin : g_bad_fract
    $error("ENGINE_FRACT_WIDTH must leave at least a sign bit");
  end
  if (H_PIXELS > (1 << PIXEL_DATA_WIDTH) || V_PIXELS > (1 << PIXEL_DATA_WIDTH)) begin : g_bad_size
    $error("frame does not fit in PIXEL_DATA_WIDTH counters");
  end

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t state, state_next;

  // Latched frame configuration; row 0's imaginary value is loaded straight into imag_y.
  logic signed [ENGINE_DATA_WIDTH-1:0] x_min_q;
  logic signed [ENGINE_DATA_WIDTH-1:0] step_q;

  logic handshake;
  logic last_col;
  logic last_row;
  logic last_pixel;

  assign handshake  = out_valid && out_ready;
  assign last_col   = (pixel_x == LAST_COL);
  assign last_row   = (pixel_y == LAST_ROW);
  assign last_pixel = last_col && last_row;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of process order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: each combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (handshake && last_pixel) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    busy      = 1'b0;
    if (state == RUN) begin
      out_valid = 1'b1;
      busy      = 1'b1;
    end
    sof = out_valid && (pixel_x == '0) && (pixel_y == '0);
    eol = out_valid && last_col;
  end

  // Pixel/coordinate datapath. Outputs hold whenever no handshake occurs,
  // including after the last pixel, so the final beat remains observable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_min_q <= '0;
      step_q  <= '0;
      pixel_x <= '0;
      pixel_y <= '0;
      real_x  <= '0;
      imag_y  <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        x_min_q <= x_min;
        step_q  <= step;
        pixel_x <= '0;
        pixel_y <= '0;
        real_x  <= x_min;
        imag_y  <= y_min;
      end
    end else if (handshake) begin
      if (!last_col) begin
        pixel_x <= pixel_x + 1'b1;
        real_x  <= real_x + step_q;
      end else if (!last_row) begin
        pixel_x <= '0;
        real_x  <= x_min_q;
        pixel_y <= pixel_y + 1'b1;
        imag_y  <= imag_y + step_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= handshake && last_pixel;
    end
  end

endmodule

// File: tb/tb_pixel_coord_gen.sv
// Bench for pixel_coord_gen on a 4x3 frame: a beat-index reference model checked
// every falling edge, plus literal checks of the key beats.
module tb_pixel_coord_gen;

  localparam int H  = 4;
  localparam int V  = 3;
  localparam int N  = H * V;
  localparam int PW = 10;
  localparam int EW = 25;
  localparam int FW = 20;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [EW-1:0] x_min = '0;
  logic [EW-1:0] y_min = '0;
  logic [EW-1:0] step = '0;
  logic          out_ready = 1'b1;
  logic          out_valid;
  logic [EW-1:0] real_x;
  logic [EW-1:0] imag_y;
  logic [PW-1:0] pixel_x;
  logic [PW-1:0] pixel_y;
  logic          sof;
  logic          eol;
  logic          busy;
  logic          frame_done;

  int tests = 0;
  int fails = 0;

  pixel_coord_gen #(
    .PIXEL_DATA_WIDTH  (PW),
    .ENGINE_DATA_WIDTH (EW),
    .ENGINE_FRACT_WIDTH(FW),
    .H_PIXELS          (H),
    .V_PIXELS          (V)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .x_min     (x_min),
    .y_min     (y_min),
    .step      (step),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .real_x    (real_x),
    .imag_y    (imag_y),
    .pixel_x   (pixel_x),
    .pixel_y   (pixel_y),
    .sof       (sof),
    .eol       (eol),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is just a beat index 0..N-1; everything the DUT
  // shows is a closed-form function of that index and the latched config.
  logic [EW-1:0] m_xmin = '0;
  logic [EW-1:0] m_ymin = '0;
  logic [EW-1:0] m_step = '0;
  int            m_idx = 0;
  bit            m_valid = 1'b0;
  bit            m_fd = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_xmin  <= '0;
      m_ymin  <= '0;
      m_step  <= '0;
      m_idx   <= 0;
      m_valid <= 1'b0;
      m_fd    <= 1'b0;
    end else if (!m_valid) begin
      m_fd <= 1'b0;
      if (start) begin
        m_xmin  <= x_min;
        m_ymin  <= y_min;
        m_step  <= step;
        m_idx   <= 0;
        m_valid <= 1'b1;
      end
    end else begin
      m_fd <= 1'b0;
      if (out_ready) begin
        if (m_idx == N - 1) begin
          m_valid <= 1'b0;
          m_fd    <= 1'b1;
        end else begin
          m_idx <= m_idx + 1;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [EW-1:0] col;
    logic [EW-1:0] row;
    logic [EW-1:0] ex_r;
    logic [EW-1:0] ex_i;
    logic [PW-1:0] ex_px;
    logic [PW-1:0] ex_py;
    col   = EW'(m_idx % H);
    row   = EW'(m_idx / H);
    ex_r  = m_xmin + col * m_step;
    ex_i  = m_ymin + row * m_step;
    ex_px = PW'(m_idx % H);
    ex_py = PW'(m_idx / H);
    check("out_valid", out_valid, m_valid);
    check("busy", busy, m_valid);
    check("frame_done", frame_done, m_fd);
    check("real_x", real_x, ex_r);
    check("imag_y", imag_y, ex_i);
    check("pixel_x", pixel_x, ex_px);
    check("pixel_y", pixel_y, ex_py);
    check("sof", sof, m_valid && m_idx == 0);
    check("eol", eol, m_valid && (m_idx % H) == H - 1);
  end

  // Presents config with start for one accepting edge; returns just after beat 0 appears.
  task automatic start_frame(input logic [EW-1:0] xm, input logic [EW-1:0] ym, input logic [EW-1:0] st);
    @(posedge clk); #1;
    x_min = xm;
    y_min = ym;
    step  = st;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Drives out_ready (percent-high) until frame_done, bounded by a cycle budget.
  task automatic run_frame(input string name, input int ready_pct);
    bit done = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clk);
      if (frame_done) begin
        done = 1'b1;
      end else begin
        @(posedge clk); #1;
        out_ready = ($urandom_range(0, 99) < ready_pct);
      end
    end
    check({name, "_done"}, done, 1'b1);
    @(posedge clk); #1;
    out_ready = 1'b1;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Basic frame with literal beat checks.
    out_ready = 1'b1;
    start_frame(25'h1E00000, 25'h1F00000, 25'h0001000);
    @(negedge clk);
    check("b0_real", real_x, 25'h1E00000);
    check("b0_imag", imag_y, 25'h1F00000);
    check("b0_sof", sof, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("b3_real", real_x, 25'h1E03000);
    check("b3_eol", eol, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("b4_real", real_x, 25'h1E00000);
    check("b4_imag", imag_y, 25'h1F01000);
    check("b4_py", pixel_y, 10'd1);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("fd_pulse", frame_done, 1'b1);
    check("fd_valid", out_valid, 1'b0);
    check("hold_px", pixel_x, 10'd3);
    check("hold_py", pixel_y, 10'd2);
    @(negedge clk);
    check("fd_single", frame_done, 1'b0);

    // Same frame under random backpressure.
    start_frame(25'h1E00000, 25'h1F00000, 25'h0001000);
    run_frame("backpressure", 50);

    // Config change mid-frame must not leak into the running frame.
    start_frame(25'h1E00000, 25'h1F00000, 25'h0001000);
    repeat (5) @(posedge clk); #1;
    step  = 25'h0002000;
    x_min = 25'($urandom);
    y_min = 25'($urandom);
    @(negedge clk);
    check("cfg_b5_real", real_x, 25'h1E01000);
    run_frame("cfgchange", 100);

    // Asynchronous reset between edges at beat 6.
    start_frame(25'h1E00000, 25'h1F00000, 25'h0001000);
    repeat (6) @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check("rst_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_real", real_x, 25'h0);
    check("rst_imag", imag_y, 25'h0);
    check("rst_px", pixel_x, 10'd0);
    check("rst_py", pixel_y, 10'd1 - 10'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    start_frame(25'h0100000, 25'h1FF0000, 25'h0000800);
    @(negedge clk);
    check("restart_px", pixel_x, 10'd0);
    check("restart_sof", sof, 1'b1);
    check("restart_real", real_x, 25'h0100000);
    run_frame("restart", 70);

    // Two's-complement wrap with no saturation.
    start_frame(25'h0FFF000, 25'h0000000, 25'h0001000);
    @(posedge clk);
    @(negedge clk);
    check("wrap_real", real_x, 25'h1000000);
    run_frame("wrap", 100);

    // start held high: back-to-back frames separated by the frame_done cycle.
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk);
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("b2b_gap_fd", frame_done, 1'b1);
    check("b2b_gap_valid", out_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("b2b_restart_valid", out_valid, 1'b1);
    check("b2b_restart_sof", sof, 1'b1);
    @(posedge clk); #1;
    start = 1'b0;
    run_frame("b2b", 100);

    // Randomised frames.
    for (int k = 0; k < 4; k++) begin
      start_frame(25'($urandom), 25'($urandom), 25'($urandom_range(0, 32'h3FFFF)));
      run_frame("random", 60);
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
